// File: rtl/hex_display_arbiter.sv
// hex_display_arbiter
// Shares the two-digit seven-segment display (HEX1:HEX0) between four
// requesters. A round-robin arbiter grants one requester at a time for a
// bounded hold window. The granted requester's live 4-bit value is shown as
// two decimal digits ("00".."15").
//
// Ports:
//   CLOCK_50  in   system clock, rising edge
//   RESET     in   asynchronous active-high reset
//   req[3:0]  in   request lines, req[i] = requester i
//   val[15:0] in   requester values, requester i uses val[4i+3:4i]
//   grant     out  registered one-hot (or zero) grant
//   busy      out  registered, high while any grant is active
//   HEX0      out  ones digit, active-low, bit 0 = seg a .. bit 6 = seg g
//   HEX1      out  tens digit, same encoding
module hex_display_arbiter #(
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int CNT_W       = 26
) (
  input  logic        CLOCK_50,
  input  logic        RESET,
  input  logic [3:0]  req,
  input  logic [15:0] val,
  output logic [3:0]  grant,
  output logic        busy,
  output logic [0:6]  HEX0,
  output logic [0:6]  HEX1
);

  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [0:6]       SEG_BLANK  = 7'b1111111;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SHOW = 1'b1
  } state_t;

  // Active-low segment pattern of one decimal digit.
  function automatic logic [0:6] seg_digit(input logic [3:0] d);
    logic [0:6] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  state_t           r_state;
  logic [1:0]       r_ptr;
  logic [CNT_W-1:0] r_cnt;

  state_t           w_state_nxt;
  logic [1:0]       w_ptr_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [3:0]       w_grant_nxt;
  logic [0:6]       w_hex0_nxt;
  logic [0:6]       w_hex1_nxt;
  logic [1:0]       w_cand;
  logic [1:0]       w_win_idx;
  logic             w_any_req;
  logic             w_rearb;
  logic             w_take;
  logic [3:0]       w_own_val;

  assign w_any_req = |req;
  // While showing, r_ptr is the index of the current owner.
  assign w_rearb   = !req[r_ptr] || (r_cnt == CNT_ZERO);

  // Round-robin winner: scan ptr+4 (= ptr, lowest priority) down to ptr+1 so
  // the last hit, i.e. the earliest in search order, is kept.
  always_comb begin
    w_cand    = r_ptr;
    w_win_idx = r_ptr;
    for (int k = 4; k >= 1; k--) begin
      w_cand = r_ptr + 2'(k);
      if (req[w_cand]) begin
        w_win_idx = w_cand;
      end else begin
        w_win_idx = w_win_idx;
      end
    end
  end

  // Next-state, pointer and hold-counter logic.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_take      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_state_nxt = ST_SHOW;
          w_take      = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SHOW: begin
        if (w_rearb) begin
          if (w_any_req) begin
            w_state_nxt = ST_SHOW;
            w_take      = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = CNT_ZERO;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = CNT_ZERO;
      end
    endcase
    if (w_take) begin
      w_ptr_nxt = w_win_idx;
      w_cnt_nxt = CNT_RELOAD;
    end else begin
      w_ptr_nxt = w_ptr_nxt;
    end
  end

  // Grant and display are derived from the next state so both update on the
  // same edge; the value is read live from the owner's val slice.
  always_comb begin
    w_grant_nxt = 4'b0000;
    w_own_val   = val[{w_ptr_nxt, 2'b00} +: 4];
    w_hex0_nxt  = SEG_BLANK;
    w_hex1_nxt  = SEG_BLANK;
    if (w_state_nxt == ST_SHOW) begin
      w_grant_nxt = 4'b0001 << w_ptr_nxt;
      if (w_own_val >= 4'd10) begin
        w_hex1_nxt = seg_digit(4'd1);
        w_hex0_nxt = seg_digit(w_own_val - 4'd10);
      end else begin
        w_hex1_nxt = seg_digit(4'd0);
        w_hex0_nxt = seg_digit(w_own_val);
      end
    end else begin
      w_grant_nxt = 4'b0000;
    end
  end

  // State, pointer, counter and registered outputs.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      r_state <= ST_IDLE;
      r_ptr   <= 2'd3;
      r_cnt   <= CNT_ZERO;
      grant   <= 4'b0000;
      busy    <= 1'b0;
      HEX0    <= SEG_BLANK;
      HEX1    <= SEG_BLANK;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
      grant   <= w_grant_nxt;
      busy    <= |w_grant_nxt;
      HEX0    <= w_hex0_nxt;
      HEX1    <= w_hex1_nxt;
    end
  end

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Testbench for hex_display_arbiter: directed scenarios with literal
// expectations plus randomized traffic, all checked every cycle against a
// behavioural ownership model (owner index + edges owned so far).
module tb_hex_display_arbiter;

  localparam int HOLD = 4;

  logic        CLOCK_50 = 1'b0;
  logic        RESET    = 1'b0;
  logic [3:0]  req      = 4'b0000;
  logic [15:0] val      = 16'h0000;
  logic [3:0]  grant;
  logic        busy;
  logic [0:6]  HEX0;
  logic [0:6]  HEX1;

  int n_checks = 0;
  int n_err    = 0;

  // Model state
  int         m_owner = -1;
  int         m_ptr   = 3;
  int         m_age   = 0;
  int         m_win;
  int         m_v;
  logic [3:0] m_grant = 4'b0000;
  logic       m_busy  = 1'b0;
  logic [0:6] m_hex0  = 7'b1111111;
  logic [0:6] m_hex1  = 7'b1111111;

  hex_display_arbiter #(.HOLD_CYCLES(HOLD), .CNT_W(3)) dut (
    .CLOCK_50 (CLOCK_50),
    .RESET    (RESET),
    .req      (req),
    .val      (val),
    .grant    (grant),
    .busy     (busy),
    .HEX0     (HEX0),
    .HEX1     (HEX1)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  function automatic logic [0:6] seg_of(input int d);
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 1; k <= 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  // Behavioural model: ownership measured in edges owned, display from
  // decimal division of the owner's current value.
  initial begin
    forever begin
      @(posedge CLOCK_50 or posedge RESET);
      if (RESET) begin
        m_owner = -1;
        m_ptr   = 3;
        m_age   = 0;
      end else begin
        m_win = pick(req, m_ptr);
        if (m_owner < 0) begin
          if (m_win >= 0) begin
            m_owner = m_win; m_ptr = m_win; m_age = 1;
          end
        end else if (!req[m_owner] || m_age >= HOLD) begin
          if (m_win >= 0) begin
            m_owner = m_win; m_ptr = m_win; m_age = 1;
          end else begin
            m_owner = -1; m_age = 0;
          end
        end else begin
          m_age++;
        end
      end
      if (m_owner >= 0) begin
        m_v     = int'(val[m_owner*4 +: 4]);
        m_grant = 4'b0001 << m_owner;
        m_busy  = 1'b1;
        m_hex1  = seg_of(m_v / 10);
        m_hex0  = seg_of(m_v % 10);
      end else begin
        m_grant = 4'b0000;
        m_busy  = 1'b0;
        m_hex1  = 7'b1111111;
        m_hex0  = 7'b1111111;
      end
    end
  end

  // Cycle-by-cycle comparison against the model on the falling edge.
  initial begin
    forever begin
      @(negedge CLOCK_50);
      if (!RESET) begin
        chk("model_grant", {4'b0000, grant}, {4'b0000, m_grant});
        chk("model_busy",  {7'b0000000, busy}, {7'b0000000, m_busy});
        chk("model_hex0",  {1'b0, HEX0}, {1'b0, m_hex0});
        chk("model_hex1",  {1'b0, HEX1}, {1'b0, m_hex1});
      end
    end
  end

  initial begin
    #1 RESET = 1'b1;
    repeat (2) tick();
    RESET = 1'b0;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_grant", {4'b0000, grant}, 8'h00);
      chk("idle_hex0", {1'b0, HEX0}, 8'h7F);
    end

    // Single requester, value 13 then 7
    req = 4'b0001; val[3:0] = 4'd13;
    tick();
    chk("g0_grant", {4'b0000, grant}, 8'b0000_0001);
    chk("v13_hex1", {1'b0, HEX1}, {1'b0, 7'b1001111});
    chk("v13_hex0", {1'b0, HEX0}, {1'b0, 7'b0000110});
    val[3:0] = 4'd7;
    tick();
    chk("v7_hex1", {1'b0, HEX1}, {1'b0, 7'b0000001});
    chk("v7_hex0", {1'b0, HEX0}, {1'b0, 7'b0001111});

    // Asynchronous reset between edges
    #2 RESET = 1'b1;
    req = 4'b0000;
    #1;
    chk("arst_grant", {4'b0000, grant}, 8'h00);
    chk("arst_busy", {7'b0000000, busy}, 8'h00);
    chk("arst_hex0", {1'b0, HEX0}, 8'h7F);
    chk("arst_hex1", {1'b0, HEX1}, 8'h7F);
    #2 RESET = 1'b0;
    tick();

    // All four requesting: rotate every HOLD cycles starting at requester 0
    req = 4'b1111;
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("rr_grant", {4'b0000, grant}, {4'b0000, 4'b0001 << ((c / 4) % 4)});
    end
    req = 4'b0000;
    tick();

    // Lone requester 2 is re-granted without gaps, then releases
    req = 4'b0100;
    for (int c = 0; c < 12; c++) begin
      tick();
      chk("solo_grant", {4'b0000, grant}, 8'b0000_0100);
    end
    req = 4'b0000;
    tick();
    chk("rel_grant", {4'b0000, grant}, 8'h00);
    chk("rel_hex0", {1'b0, HEX0}, 8'h7F);
    chk("rel_hex1", {1'b0, HEX1}, 8'h7F);

    // Early release by requester 1 hands over to requester 3 with a full window
    req = 4'b0010;
    tick();
    chk("er_g1", {4'b0000, grant}, 8'b0000_0010);
    req = 4'b1010;
    tick();
    req = 4'b1000;
    tick();
    chk("er_g3", {4'b0000, grant}, 8'b0000_1000);
    req = 4'b1001;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("er_hold3", {4'b0000, grant}, 8'b0000_1000);
    end
    tick();
    chk("er_next0", {4'b0000, grant}, 8'b0000_0001);

    // Value sweep through requester 2; other nibbles are noise
    val = 16'h0000;
    req = 4'b0100;
    tick();
    chk("sw_grant", {4'b0000, grant}, 8'b0000_0100);
    for (int v = 0; v < 16; v++) begin
      val = 16'($urandom);
      val[11:8] = 4'(v);
      tick();
      chk("sweep_hex1", {1'b0, HEX1}, {1'b0, seg_of(v / 10)});
      chk("sweep_hex0", {1'b0, HEX0}, {1'b0, seg_of(v % 10)});
    end

    // Randomized traffic with occasional asynchronous resets
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(3) == 0) req = 4'($urandom);
      if ($urandom_range(1) == 0) val = 16'($urandom);
      if ($urandom_range(199) == 0) begin
        RESET = 1'b1;
        #3 RESET = 1'b0;
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/hex_display_arbiter.md
# hex_display_arbiter

Round-robin arbiter and sequencer that shares the board's two-digit seven-segment display (HEX1:HEX0) between four requesters, each supplying a 4-bit binary value. The granted requester owns the display for a bounded hold window. Its value is shown as two decimal digits: 0–15 → "00"–"15". The block sits between the lab's value-producing sub-blocks and the HEX pins and replaces per-block direct drive of the display.

## Interface
- HOLD_CYCLES, 50_000_000, maximum ownership window in clock cycles; must be ≥ 1.
- CNT_W, 26, hold counter width; 2^CNT_W must be > HOLD_CYCLES − 1.

- CLOCK_50  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- req  in  4  request lines; req[i] is requester i.
- val  in  16  requester values; requester i uses val[4i+3:4i], unsigned 0–15.
- grant  out  4  registered, one-hot or zero; grant[i] = requester i owns the display.
- busy  out  1  registered; 1 when any grant is active (= |grant).
- HEX0  out  [0:6]  ones digit, active-low; bit 0 = segment a … bit 6 = segment g.
- HEX1  out  [0:6]  tens digit; same encoding as HEX0.

## Operation
- State machine, 2 states:
  - IDLE: no grant; display blank.
  - SHOW: one grant active; hold counter running.
- Round-robin pointer `ptr` (2 bits) holds the index of the last granted requester.
  - Search order: ptr+1, ptr+2, ptr+3, ptr (mod 4).
  - The first asserted req in that order wins, and `ptr` takes the winner's index.
- IDLE → SHOW: any req asserted at a clock edge. Grant the winner, load counter = HOLD_CYCLES−1.
- In SHOW, each edge checks in priority order:
  - Granted requester's req low (early release), or counter == 0 (expiry): re-arbitrate at that edge.
    - If any req is high: grant the new winner, reload the counter, stay in SHOW. This is back-to-back with no idle gap.
    - If the same requester is the only one requesting, it is re-granted: grant stays high, counter reloads.
    - If no req is high: go to IDLE, clear grant.
  - Otherwise: decrement the counter.
- Display decode of granted value v:
  - v ≤ 9: HEX1 = "0", HEX0 = digit v.
  - v ≥ 10: HEX1 = "1", HEX0 = digit v−10.
- Segment codes:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - blank=1111111
- The display tracks the granted requester's live val; the value is not latched at grant.

## Timing
- Reset values (asserted asynchronously, including mid-SHOW): state=IDLE, grant=0000, busy=0, HEX0=HEX1=1111111, ptr=3 (requester 0 has first priority), counter=0.
- Grant latency: req sampled high at edge t in IDLE → grant, busy and HEX valid immediately after edge t.
- HEX0/HEX1 are registered and computed from the next-state grant and current val, so grant and display always change on the same edge.
- A val change while granted appears on HEX one edge later. Values of ungranted requesters are ignored.
- Full window: with req held continuously, ownership lasts exactly HOLD_CYCLES edges.
- HOLD_CYCLES=1: re-arbitration on every edge.
- Early release: req drop sampled at edge t → grant changes at edge t. The display blanks at t if no other requester is pending.
- Simultaneous requests: resolved purely by `ptr`; requester index carries no fixed priority.
- No starvation: a requester holding req high is granted within 3 windows.

## Test plan
- Reset then idle, HOLD_CYCLES=4, req=0000 → grant=0000, busy=0, HEX0=HEX1=1111111 for 10 cycles; RESET asserted mid-cycle blanks outputs without waiting for a clock edge.
- req=0001, val[3:0]=13 → next edge: grant=0001, HEX1=1001111, HEX0=0000110; change val[3:0] to 7 → one edge later HEX1=0000001, HEX0=0001111.
- req=1111 held, HOLD_CYCLES=4 → grants 0001,0010,0100,1000,0001 each lasting exactly 4 cycles, with no blank cycles between them.
- req=0100 only, held for 12 cycles → grant=0100 stays high continuously, counter reloads every 4 cycles; then drop req → next edge grant=0000, display blank.
- Requester 1 granted, drops req after 2 cycles while req[3]=1 → grant=1000 on that edge, and the counter restarts at 3.
- Sweep val 0–15 through requester 2 → HEX1/HEX0 match "00".."15" using the segment table above.
